// File: rtl/quadra_pkg.sv
// Shared types and constants for the quadra evaluator and its output buffer.
package quadra_pkg;

  localparam int Y_W        = 32;
  localparam int LATENCY    = 3;
  localparam int DEPTH_DEF  = 8;

  typedef logic [Y_W-1:0]              y_t;
  typedef logic                        dv_t;
  typedef logic [$clog2(DEPTH_DEF):0]  cnt_t;

endpackage

// File: rtl/quadra_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head register.
module quadra_fifo
  import quadra_pkg::*;
#(
  parameter int W     = Y_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_next = rd_ptr + 1'b1;

  // NOTE: storage has no reset; only pointers and count define what is valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every read
  // below sees the value from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Head tracks the oldest word; a push becomes head only when it would be the sole entry.
      if (do_push && (empty || (do_pop && cnt == CW'(1))))
        dout <= din;
      else if (do_pop && cnt > CW'(1))
        dout <= mem[rd_next];
    end
  end

endmodule

// File: rtl/quadra_out_buf.sv
// Output buffer for the quadra result stream: absorbs y/y_dv into a FIFO,
// issues credit to the x source, and flags overflow and protocol misuse.
module quadra_out_buf
  import quadra_pkg::*;
#(
  parameter int Y_W     = quadra_pkg::Y_W,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = quadra_pkg::LATENCY
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    x_dv_i,
  output logic                    x_rdy_o,
  input  logic [Y_W-1:0]          y_i,
  input  logic                    y_dv_i,
  output logic [Y_W-1:0]          m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    ovf_o,
  output logic                    err_o,
  output logic [$clog2(DEPTH):0]  cnt_o
);

  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(DEPTH) + 2;

  logic [IW-1:0] inflight;
  logic [SW-1:0] sum;
  logic          full;
  logic          empty;
  logic          pop;
  logic          at_max;
  logic          at_zero;
  logic          drop;
  logic          proto_err;

  quadra_fifo #(.W(Y_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (y_dv_i),
    .din   (y_i),
    .pop   (pop),
    .dout  (m_data_o),
    .full  (full),
    .empty (empty),
    .cnt   (cnt_o)
  );

  assign m_valid_o = ~empty;
  assign pop       = m_valid_o & m_ready_i;

  // Credit depends only on registered occupancy and in-flight count.
  assign sum     = SW'(cnt_o) + SW'(inflight);
  assign x_rdy_o = (sum < SW'(DEPTH));

  assign at_max  = (inflight == IW'(LATENCY));
  assign at_zero = (inflight == '0);
  assign drop    = y_dv_i & full & ~pop;

  // A retiring result in the same cycle makes room, so x_dv at LATENCY is only
  // an error when nothing leaves the pipeline alongside it.
  assign proto_err = (x_dv_i & ~x_rdy_o)
                   | (x_dv_i & ~y_dv_i & at_max)
                   | (y_dv_i & at_zero);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight <= '0;
      ovf_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (x_dv_i && !y_dv_i && !at_max)
        inflight <= inflight + 1'b1;
      else if (y_dv_i && !x_dv_i && !at_zero)
        inflight <= inflight - 1'b1;
      if (drop)      ovf_o <= 1'b1;
      if (proto_err) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quadra_out_buf.sv
// Directed self-checking bench for quadra_out_buf at DEPTH=4, LATENCY=3.
module tb_quadra_out_buf;

  localparam int Y_W = 32;
  localparam int DEPTH = 4;
  localparam int LATENCY = 3;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            x_dv_i = 1'b0;
  logic            x_rdy_o;
  logic [Y_W-1:0]  y_i = '0;
  logic            y_dv_i = 1'b0;
  logic [Y_W-1:0]  m_data_o;
  logic            m_valid_o;
  logic            m_ready_i = 1'b0;
  logic            ovf_o;
  logic            err_o;
  logic [2:0]      cnt_o;

  int total = 0;
  int bad = 0;

  quadra_out_buf #(.Y_W(Y_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .x_dv_i    (x_dv_i),
    .x_rdy_o   (x_rdy_o),
    .y_i       (y_i),
    .y_dv_i    (y_dv_i),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .ovf_o     (ovf_o),
    .err_o     (err_o),
    .cnt_o     (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Issue 4 samples back to back while credit allows; results return 3 cycles later.
  task automatic load4(input logic [31:0] base);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("load_rdy_c%0d", c), 32'(x_rdy_o), 32'(c < 4));
      x_dv_i = (c < 4);
      y_dv_i = (c >= 3) && (c < 7);
      y_i    = base + 32'(c) - 32'd3;
      step();
    end
    x_dv_i = 1'b0;
    y_dv_i = 1'b0;
  endtask

  initial begin
    // Reset then idle
    step();
    step();
    rst_i = 1'b0;
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_data",  m_data_o,       32'd0);
    check("rst_cnt",   32'(cnt_o),     32'd0);
    check("rst_rdy",   32'(x_rdy_o),   32'd1);
    check("rst_ovf",   32'(ovf_o),     32'd0);
    check("rst_err",   32'(err_o),     32'd0);

    // Single result, issued legally three cycles after its sample
    x_dv_i = 1'b1;
    step();
    x_dv_i = 1'b0;
    step();
    step();
    y_dv_i = 1'b1;
    y_i    = 32'h0000_00A5;
    step();
    y_dv_i = 1'b0;
    check("one_valid", 32'(m_valid_o), 32'd1);
    check("one_data",  m_data_o,       32'h0000_00A5);
    check("one_cnt",   32'(cnt_o),     32'd1);
    check("one_err",   32'(err_o),     32'd0);
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
    check("one_pop_valid", 32'(m_valid_o), 32'd0);
    check("one_pop_cnt",   32'(cnt_o),     32'd0);

    // Credit throttling
    load4(32'd1);
    check("thr_cnt", 32'(cnt_o),   32'd4);
    check("thr_rdy", 32'(x_rdy_o), 32'd0);
    check("thr_ovf", 32'(ovf_o),   32'd0);
    check("thr_err", 32'(err_o),   32'd0);
    m_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("thr_drain_v%0d", i), 32'(m_valid_o), 32'd1);
      check($sformatf("thr_drain_d%0d", i), m_data_o, 32'(i));
      step();
    end
    m_ready_i = 1'b0;
    check("thr_empty", 32'(m_valid_o), 32'd0);
    check("thr_rdy_back", 32'(x_rdy_o), 32'd1);

    // Full with simultaneous push and pop
    load4(32'd10);
    check("full_cnt", 32'(cnt_o), 32'd4);
    check("full_head", m_data_o, 32'd10);
    m_ready_i = 1'b1;
    y_dv_i    = 1'b1;
    y_i       = 32'd14;
    step();
    m_ready_i = 1'b0;
    y_dv_i    = 1'b0;
    check("pp_cnt",  32'(cnt_o), 32'd4);
    check("pp_head", m_data_o,   32'd11);
    check("pp_ovf",  32'(ovf_o), 32'd0);

    // Overflow: word dropped, contents intact
    y_dv_i = 1'b1;
    y_i    = 32'h0000_DEAD;
    step();
    y_dv_i = 1'b0;
    check("ovf_flag", 32'(ovf_o), 32'd1);
    check("ovf_cnt",  32'(cnt_o), 32'd4);
    check("ovf_head", m_data_o,   32'd11);
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain_d%0d", i), m_data_o, 32'd11 + 32'(i));
      step();
    end
    m_ready_i = 1'b0;
    check("ovf_empty",  32'(m_valid_o), 32'd0);
    check("ovf_sticky", 32'(ovf_o),     32'd1);

    // Protocol error: x_dv without credit, then reset with 3 words queued
    load4(32'd20);
    check("pe_rdy", 32'(x_rdy_o), 32'd0);
    x_dv_i = 1'b1;
    step();
    x_dv_i = 1'b0;
    check("pe_err", 32'(err_o), 32'd1);
    check("pe_rdy_after", 32'(x_rdy_o), 32'd0);
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
    check("pe_cnt3",  32'(cnt_o), 32'd3);
    check("pe_head",  m_data_o,   32'd21);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_rst_cnt",   32'(cnt_o),     32'd0);
    check("mid_rst_valid", 32'(m_valid_o), 32'd0);
    check("mid_rst_ovf",   32'(ovf_o),     32'd0);
    check("mid_rst_err",   32'(err_o),     32'd0);
    check("mid_rst_rdy",   32'(x_rdy_o),   32'd1);
    check("mid_rst_data",  m_data_o,       32'd0);

    // y_dv with nothing in flight: error, but the word is still kept
    y_dv_i = 1'b1;
    y_i    = 32'h0000_0077;
    step();
    y_dv_i = 1'b0;
    check("orph_err",  32'(err_o),     32'd1);
    check("orph_cnt",  32'(cnt_o),     32'd1);
    check("orph_data", m_data_o,       32'h0000_0077);
    check("orph_ovf",  32'(ovf_o),     32'd0);
    step();
    check("orph_err_sticky", 32'(err_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
